// File: rtl/l1d_package.sv
// l1d_package: shared L1D types and defaults.
//   pack_l1d_data_ram_req  - data RAM request payload
//   REQ_DE_WIDTH           - byte-enable width of a RAM write
//   L1D_MSHR_ID_WIDTH      - MSHR id width
//   L1D_DATA_ARB_*         - default sizing of the data RAM arbiter
package l1d_package;

   localparam int unsigned L1D_MSHR_ID_WIDTH          = 4;
   localparam int unsigned REQ_DE_WIDTH               = 8;
   localparam int unsigned L1D_DATA_RAM_IDX_WIDTH     = 6;
   localparam int unsigned L1D_DATA_RAM_WAY_WIDTH     = 2;
   localparam int unsigned L1D_DATA_RAM_DATA_WIDTH    = 64;

   localparam int unsigned L1D_DATA_ARB_NUM_SRC       = 4;
   localparam int unsigned L1D_DATA_ARB_STARVE_LIMIT  = 8;

   typedef struct packed {
      logic                               op_is_read;
      logic [L1D_DATA_RAM_IDX_WIDTH-1:0]  index;
      logic [L1D_DATA_RAM_WAY_WIDTH-1:0]  way;
      logic [REQ_DE_WIDTH-1:0]            wr_data_be;
      logic [L1D_DATA_RAM_DATA_WIDTH-1:0] wr_data;
   } pack_l1d_data_ram_req;

   // Refill beats always write the full line slice.
   function automatic pack_l1d_data_ram_req linefill_override(input pack_l1d_data_ram_req p);
      pack_l1d_data_ram_req r;
      r            = p;
      r.op_is_read = 1'b0;
      r.wr_data_be = '1;
      return r;
   endfunction

endpackage

// File: rtl/l1d_starve_prio_arb.sv
// l1d_starve_prio_arb: fixed-priority grant with starvation promotion.
//   clk, rst   - clock, synchronous active-high reset
//   req_vld    - per-source request valid
//   out_free   - downstream stage can take a request this cycle
//   req_rdy    - per-source accept (grant qualified by out_free)
module l1d_starve_prio_arb #(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req_vld,
   input  logic               out_free,
   output logic [NUM_SRC-1:0] req_rdy
);

   localparam int unsigned          CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]   cnt_q [NUM_SRC];
   logic [CNT_W-1:0]   cnt_d [NUM_SRC];
   logic [NUM_SRC-1:0] starved;
   logic [NUM_SRC-1:0] grant;
   logic               any_starved;
   logic               found;

   always_comb begin
      starved     = '0;
      grant       = '0;
      found       = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         starved[i] = req_vld[i] && (cnt_q[i] == CNT_MAX);
      end
      any_starved = |starved;
      // Starved sources mask the static order; among them lowest index wins.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!found && (any_starved ? starved[i] : req_vld[i])) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      req_rdy = grant & {NUM_SRC{out_free}};
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (req_vld[i] && !req_rdy[i]) begin
            cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (rst) cnt_q[i] <= '0;
         else     cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: rtl/l1d_data_ram_arbiter.sv
// l1d_data_ram_arbiter: N-source arbiter in front of the L1D data RAM.
//   src_req_vld/rdy/pld   - per-source request handshake and payload
//   linefill_last/id      - last-beat qualifier and MSHR id for LINEFILL_SRC
//   data_ram_req_vld/rdy/pld - registered one-entry RAM request stage
//   linefill_done_en/id   - one-cycle pulse after a line's last beat
//   beat_err              - sticky beat count / last mismatch flag
module l1d_data_ram_arbiter
   import l1d_package::*;
#(
   parameter int unsigned NUM_SRC        = L1D_DATA_ARB_NUM_SRC,
   parameter int unsigned STARVE_LIMIT   = L1D_DATA_ARB_STARVE_LIMIT,
   parameter int unsigned LINEFILL_SRC   = 2,
   parameter int unsigned BEATS_PER_LINE = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_SRC-1:0]                  src_req_vld,
   output logic [NUM_SRC-1:0]                  src_req_rdy,
   input  pack_l1d_data_ram_req [NUM_SRC-1:0]  src_req_pld,
   input  logic                                linefill_last,
   input  logic [L1D_MSHR_ID_WIDTH-1:0]        linefill_id,
   output logic                                data_ram_req_vld,
   input  logic                                data_ram_req_rdy,
   output pack_l1d_data_ram_req                data_ram_req_pld,
   output logic                                linefill_done_en,
   output logic [L1D_MSHR_ID_WIDTH-1:0]        linefill_done_id,
   output logic                                beat_err
);

   localparam int unsigned      BEAT_W    = $clog2(BEATS_PER_LINE);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_LINE - 1);

   logic                         req_vld_q, req_vld_d;
   pack_l1d_data_ram_req         req_pld_q, req_pld_d;
   logic                         done_en_q, done_en_d;
   logic [L1D_MSHR_ID_WIDTH-1:0] done_id_q, done_id_d;
   logic                         beat_err_q, beat_err_d;
   logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;

   logic                         out_free;
   logic                         accept;
   logic                         lf_hs;
   pack_l1d_data_ram_req         acc_pld;

   assign out_free = !req_vld_q || data_ram_req_rdy;

   l1d_starve_prio_arb #(
      .NUM_SRC      (NUM_SRC),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (src_req_vld),
      .out_free (out_free),
      .req_rdy  (src_req_rdy)
   );

   always_comb begin
      accept  = 1'b0;
      acc_pld = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (src_req_vld[i] && src_req_rdy[i]) begin
            accept  = 1'b1;
            acc_pld = (i == LINEFILL_SRC) ? linefill_override(src_req_pld[i])
                                          : src_req_pld[i];
         end
      end

      req_vld_d = req_vld_q;
      req_pld_d = req_pld_q;
      if (accept) begin
         req_vld_d = 1'b1;
         req_pld_d = acc_pld;
      end else if (data_ram_req_rdy) begin
         req_vld_d = 1'b0;
      end

      lf_hs      = src_req_vld[LINEFILL_SRC] && src_req_rdy[LINEFILL_SRC];
      beat_cnt_d = beat_cnt_q;
      beat_err_d = beat_err_q;
      done_en_d  = 1'b0;
      done_id_d  = done_id_q;
      if (lf_hs) begin
         if (linefill_last) begin
            beat_cnt_d = '0;
            done_en_d  = 1'b1;
            done_id_d  = linefill_id;
            if (beat_cnt_q != BEAT_LAST) beat_err_d = 1'b1;
         end else if (beat_cnt_q == BEAT_LAST) begin
            // Missing last on the final beat: flag it and start a fresh line.
            beat_cnt_d = '0;
            beat_err_d = 1'b1;
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_vld_q  <= 1'b0;
         req_pld_q  <= '0;
         done_en_q  <= 1'b0;
         done_id_q  <= '0;
         beat_err_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         req_vld_q  <= req_vld_d;
         req_pld_q  <= req_pld_d;
         done_en_q  <= done_en_d;
         done_id_q  <= done_id_d;
         beat_err_q <= beat_err_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign data_ram_req_vld = req_vld_q;
   assign data_ram_req_pld = req_pld_q;
   assign linefill_done_en = done_en_q;
   assign linefill_done_id = done_id_q;
   assign beat_err         = beat_err_q;

endmodule

// File: tb/tb_l1d_data_ram_arbiter.sv
// tb_l1d_data_ram_arbiter: directed bench with a payload scoreboard for
// l1d_data_ram_arbiter (4 sources, starve limit 8, refill on source 2).
module tb_l1d_data_ram_arbiter;
   import l1d_package::*;

   logic                                clk = 1'b0;
   logic                                rst;
   logic [3:0]                          src_req_vld;
   logic [3:0]                          src_req_rdy;
   pack_l1d_data_ram_req [3:0]          src_req_pld;
   logic                                linefill_last;
   logic [L1D_MSHR_ID_WIDTH-1:0]        linefill_id;
   logic                                data_ram_req_vld;
   logic                                data_ram_req_rdy;
   pack_l1d_data_ram_req                data_ram_req_pld;
   logic                                linefill_done_en;
   logic [L1D_MSHR_ID_WIDTH-1:0]        linefill_done_id;
   logic                                beat_err;

   int tests = 0;
   int fails = 0;
   pack_l1d_data_ram_req sb_q [$];

   l1d_data_ram_arbiter #(
      .NUM_SRC        (4),
      .STARVE_LIMIT   (8),
      .LINEFILL_SRC   (2),
      .BEATS_PER_LINE (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .src_req_vld      (src_req_vld),
      .src_req_rdy      (src_req_rdy),
      .src_req_pld      (src_req_pld),
      .linefill_last    (linefill_last),
      .linefill_id      (linefill_id),
      .data_ram_req_vld (data_ram_req_vld),
      .data_ram_req_rdy (data_ram_req_rdy),
      .data_ram_req_pld (data_ram_req_pld),
      .linefill_done_en (linefill_done_en),
      .linefill_done_id (linefill_done_id),
      .beat_err         (beat_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pack_l1d_data_ram_req mk(input int s, input int k);
      pack_l1d_data_ram_req p;
      p.op_is_read = k[0];
      p.index      = 6'(k * 3 + s);
      p.way        = 2'(s);
      p.wr_data_be = 8'(15 ^ s);
      p.wr_data    = {32'(s * 16 + 7), 32'(k * 257 + 1)};
      return p;
   endfunction

   function automatic pack_l1d_data_ram_req lf(input pack_l1d_data_ram_req p);
      pack_l1d_data_ram_req r;
      r            = p;
      r.op_is_read = 1'b0;
      r.wr_data_be = 8'hFF;
      return r;
   endfunction

   // Scoreboard: every completed RAM handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && data_ram_req_vld && data_ram_req_rdy) begin
         tests++;
         assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_underflow: observed unexpected request %0h expected none", data_ram_req_pld);
         end
         if (sb_q.size() != 0) chk("sb_payload", 128'(data_ram_req_pld), 128'(sb_q.pop_front()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      src_req_vld   = '0;
      linefill_last = 1'b0;
      repeat (n) step();
   endtask

   // Drive nb refill beats on source 2; last asserted on beat index last_at.
   task automatic linefill(input int nb, input int last_at, input logic [3:0] id, input int kbase);
      src_req_vld = 4'b0100;
      linefill_id = id;
      for (int b = 0; b < nb; b++) begin
         src_req_pld[2] = mk(2, kbase + 2 * b + 1);
         linefill_last  = (b == last_at);
         #1;
         chk("lf_rdy", 128'(src_req_rdy), 128'(4'b0100));
         if (b > 0) chk("lf_no_early_done", 128'(linefill_done_en), 128'(0));
         sb_q.push_back(lf(mk(2, kbase + 2 * b + 1)));
         step();
      end
      src_req_vld   = '0;
      linefill_last = 1'b0;
   endtask

   initial begin
      logic [3:0] eg;
      rst              = 1'b1;
      src_req_vld      = '0;
      src_req_pld      = '0;
      linefill_last    = 1'b0;
      linefill_id      = '0;
      data_ram_req_rdy = 1'b1;
      repeat (3) step();

      // Reset state
      chk("rst_vld",      128'(data_ram_req_vld), 128'(0));
      chk("rst_pld",      128'(data_ram_req_pld), 128'(0));
      chk("rst_done_en",  128'(linefill_done_en), 128'(0));
      chk("rst_done_id",  128'(linefill_done_id), 128'(0));
      chk("rst_beat_err", 128'(beat_err),         128'(0));
      chk("rst_rdy",      128'(src_req_rdy),      128'(0));
      rst = 1'b0;
      step();

      // Priority with starvation promotion of source 3
      src_req_vld = 4'b1001;
      for (int c = 0; c < 10; c++) begin
         src_req_pld[0] = mk(0, c);
         src_req_pld[3] = mk(3, c);
         #1;
         eg = (c == 8) ? 4'b1000 : 4'b0001;
         chk("prio_grant", 128'(src_req_rdy), 128'(eg));
         sb_q.push_back(mk((c == 8) ? 3 : 0, c));
         step();
      end
      idle(3);

      // Backpressure: held request, no accepts, stable payload
      src_req_vld    = 4'b0001;
      src_req_pld[0] = mk(0, 20);
      #1;
      chk("bp_first_accept", 128'(src_req_rdy), 128'(4'b0001));
      sb_q.push_back(mk(0, 20));
      step();
      data_ram_req_rdy = 1'b0;
      src_req_vld      = 4'b0011;
      src_req_pld[0]   = mk(0, 21);
      src_req_pld[1]   = mk(1, 21);
      repeat (5) begin
         #1;
         chk("bp_rdy_low", 128'(src_req_rdy),      128'(0));
         chk("bp_vld_held", 128'(data_ram_req_vld), 128'(1));
         chk("bp_pld_held", 128'(data_ram_req_pld), 128'(mk(0, 20)));
         step();
      end
      data_ram_req_rdy = 1'b1;
      #1;
      chk("bp_release_accept", 128'(src_req_rdy), 128'(4'b0001));
      sb_q.push_back(mk(0, 21));
      step();
      src_req_vld = 4'b0010;
      #1;
      chk("bp_next_src1", 128'(src_req_rdy), 128'(4'b0010));
      sb_q.push_back(mk(1, 21));
      step();
      idle(3);

      // Clean 4-beat linefill
      linefill(4, 3, 4'd5, 0);
      chk("lf_done_en",   128'(linefill_done_en), 128'(1));
      chk("lf_done_id",   128'(linefill_done_id), 128'(5));
      chk("lf_done_vld",  128'(data_ram_req_vld), 128'(1));
      chk("lf_beat_err",  128'(beat_err),         128'(0));
      step();
      chk("lf_done_width", 128'(linefill_done_en), 128'(0));
      idle(2);

      // Early last sets sticky beat_err; next full line still completes
      linefill(2, 1, 4'd7, 10);
      chk("mm_done_en",   128'(linefill_done_en), 128'(1));
      chk("mm_done_id",   128'(linefill_done_id), 128'(7));
      chk("mm_beat_err",  128'(beat_err),         128'(1));
      step();
      linefill(4, 3, 4'd9, 20);
      chk("mm2_done_en",  128'(linefill_done_en), 128'(1));
      chk("mm2_done_id",  128'(linefill_done_id), 128'(9));
      chk("mm2_sticky",   128'(beat_err),         128'(1));
      idle(3);

      // Simultaneous starvation of sources 1 and 3
      src_req_vld = 4'b1011;
      for (int c = 0; c < 11; c++) begin
         src_req_pld[0] = mk(0, 30 + c);
         src_req_pld[1] = mk(1, 30 + c);
         src_req_pld[3] = mk(3, 30 + c);
         #1;
         eg = (c == 8) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0001;
         chk("starve_grant", 128'(src_req_rdy), 128'(eg));
         sb_q.push_back(mk((c == 8) ? 1 : (c == 9) ? 3 : 0, 30 + c));
         step();
      end
      idle(3);

      // Reset mid-operation with a held request and two beats counted
      linefill(2, -1, 4'd3, 40);
      data_ram_req_rdy = 1'b0;
      rst              = 1'b1;
      void'(sb_q.pop_back());
      #1;
      chk("mid_rst_pre_vld", 128'(data_ram_req_vld), 128'(1));
      step();
      chk("mid_rst_vld",      128'(data_ram_req_vld), 128'(0));
      chk("mid_rst_pld",      128'(data_ram_req_pld), 128'(0));
      chk("mid_rst_done_en",  128'(linefill_done_en), 128'(0));
      chk("mid_rst_done_id",  128'(linefill_done_id), 128'(0));
      chk("mid_rst_beat_err", 128'(beat_err),         128'(0));
      rst              = 1'b0;
      data_ram_req_rdy = 1'b1;
      step();
      linefill(4, 3, 4'd6, 50);
      chk("post_rst_done_en", 128'(linefill_done_en), 128'(1));
      chk("post_rst_done_id", 128'(linefill_done_id), 128'(6));
      chk("post_rst_no_err",  128'(beat_err),         128'(0));
      idle(4);

      chk("sb_drained", 128'(sb_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/l1d_data_ram_arbiter.md
# l1d_data_ram_arbiter

Parametrised N-source arbiter in front of the L1D data RAM. It succeeds the fixed four-way data pipe arbiter. Sources have fixed priority, with starvation promotion so that no source waits forever. A one-entry registered output stage drives the RAM request, and linefill beats are counted with a registered done pulse and beat-mismatch detection. It sits between the tag pipe, MSHR rw/evict, downstream refill paths and the data RAM.

## Interface
- NUM_SRC, 4: number of requesters; index 0 has the highest static priority.
- STARVE_LIMIT, 8: cycles a valid, unserved source waits before promotion; must be ≥1.
- LINEFILL_SRC, 2: index of the downstream refill source.
- BEATS_PER_LINE, 4: beats per linefill; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- src_req_vld  in  NUM_SRC  per-source request valid.
- src_req_rdy  out  NUM_SRC  per-source accept.
- src_req_pld  in  NUM_SRC × pack_l1d_data_ram_req  per-source payload.
- linefill_last  in  1  wr_last qualifier for LINEFILL_SRC.
- linefill_id  in  L1D_MSHR_ID_WIDTH  MSHR id of the current linefill beat.
- data_ram_req_vld  out  1  registered RAM request valid.
- data_ram_req_rdy  in  1  RAM accept.
- data_ram_req_pld  out  pack_l1d_data_ram_req  registered RAM payload.
- linefill_done_en  out  1  one-cycle pulse when a line completes.
- linefill_done_id  out  L1D_MSHR_ID_WIDTH  id for the done pulse.
- beat_err  out  1  sticky beat/last mismatch flag; cleared only by rst.

## Operation
- Starvation counters: one per source, width $clog2(STARVE_LIMIT+1).
  - Counter increments when vld && !rdy; saturates at STARVE_LIMIT.
  - Counter clears on that source's handshake or when its vld is low.
  - A source is starved when its counter equals STARVE_LIMIT.
- Grant: if any valid source is starved, the lowest-index starved source wins. Otherwise the lowest-index valid source wins. Grant is one-hot or zero.
- Accept condition: src_req_rdy[i] = grant[i] && (!data_ram_req_vld || data_ram_req_rdy).
- Output register loads on accept. It clears valid when data_ram_req_rdy is high and there is no new accept.
- Linefill payload override: for LINEFILL_SRC, op_is_read is forced to 0 and wr_data_be to {REQ_DE_WIDTH{1'b1}}. All other fields pass through.
- Beat counter: width $clog2(BEATS_PER_LINE); increments on each LINEFILL_SRC handshake.
  - With linefill_last: counter resets to 0; done pulse is registered with linefill_id.
  - beat_err sets when last arrives with counter ≠ BEATS_PER_LINE-1.
  - beat_err also sets when counter = BEATS_PER_LINE-1 and the handshake has no last; the counter then wraps to 0.

## Timing
- Reset values: data_ram_req_vld=0, data_ram_req_pld=0, linefill_done_en=0, linefill_done_id=0, beat_err=0, all counters 0.
- src_req_rdy is combinational from vld, the counters and data_ram_req_rdy. The RAM request appears 1 cycle after acceptance.
- Full throughput: one accept per cycle while data_ram_req_rdy stays high.
- When the output is held and data_ram_req_rdy=0, every rdy is 0. The held payload stays stable, and counters of waiting sources keep incrementing.
- linefill_done_en pulses in the cycle after the last-beat handshake, coincident with that beat's data_ram_req_vld. Its width is exactly 1 cycle.
- When several starved sources are valid at once, the lowest index wins. The others stay saturated and win in order on later accepts.
- rst mid-operation discards the held request and any partial beat count. No done pulse is issued.

## Structure
- l1d_package holds:
  - existing pack_l1d_data_ram_req, REQ_DE_WIDTH and L1D_MSHR_ID_WIDTH;
  - new defaults L1D_DATA_ARB_NUM_SRC and L1D_DATA_ARB_STARVE_LIMIT.
- One sub-module, l1d_starve_prio_arb (counters + grant), parametrised by NUM_SRC and STARVE_LIMIT. The top level holds the output register, linefill override and beat counter.

## Test plan
- Priority: sources 0 and 3 are valid continuously, RAM always ready, STARVE_LIMIT=8.
  - Source 0 is granted cycles 0–7.
  - Source 3's counter reaches 8; source 3 is granted in cycle 8; source 0 resumes in cycle 9.
- Backpressure: one request accepted, then data_ram_req_rdy=0 for 5 cycles.
  - All src_req_rdy stay 0 and the payload is unchanged.
  - The request completes on the first ready cycle, and the next accept happens in that same cycle.
- Linefill: 4 beats on source 2, id=5, last on beat 4.
  - Each RAM write has op_is_read=0 and all-ones byte enables.
  - linefill_done_en=1, id=5, one cycle after the 4th accept; beat_err stays 0.
- Mismatch: last on beat 2 sets beat_err, which stays set. A following 4-beat line still pulses done.
- Simultaneous starvation: sources 1 and 3 both starved → 1 granted, then 3.
- Reset mid-operation: rst asserted while data_ram_req_vld=1 and 2 beats pending.
  - Next cycle all outputs are 0.
  - The next linefill needs a full 4 beats and no beat_err is raised.
